// File: rtl/rng_byte_serializer.sv
// Captures a DATA_W-bit random word on the rising edge of in_valid and streams it out
// least-significant byte first over valid/ready. Define RNG_SER_OVERRUN_CNT_EN to build the dropped-word counter.
module rng_byte_serializer #(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              in_valid_q;
    logic              rise;
    logic              at_last;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    assign rise    = in_valid & ~in_valid_q;
    assign at_last = (idx == LAST_IDX);
    assign busy    = (state == S_STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            in_valid_q <= 1'b0;
            shreg      <= '0;
            idx        <= '0;
        end else begin
            state      <= state_nxt;
            in_valid_q <= in_valid;
            shreg      <= shreg_nxt;
            idx        <= idx_nxt;
        end
    end

    // Outputs depend only on registered state, so out_ready never reaches out_valid/out_data.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'd0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_STREAM;
                    shreg_nxt = in_data;
                    idx_nxt   = '0;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_last  = at_last;
                out_data  = shreg[7:0];
                if (out_ready) begin
                    if (at_last) begin
                        state_nxt = S_IDLE;
                    end else begin
                        shreg_nxt = shreg >> 8;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef RNG_SER_OVERRUN_CNT_EN
    logic [7:0] ovr_q;

    // A rise seen while streaming (final handshake cycle included) is a dropped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 8'd0;
        end else if (rise && (state == S_STREAM) && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rng_byte_serializer.sv
// Self-checking bench for rng_byte_serializer: a byte-queue reference model predicts every
// output cycle by cycle while scenario tasks drive randomized words and handshakes.
`timescale 1ns/1ps
module tb_rng_byte_serializer;

    localparam int DATA_W = 512;
    localparam int NB     = DATA_W / 8;

`ifdef RNG_SER_OVERRUN_CNT_EN
    localparam logic [7:0] ONE_CNT = 8'd1;
    localparam logic [7:0] SAT_CNT = 8'd255;
`else
    localparam logic [7:0] ONE_CNT = 8'd0;
    localparam logic [7:0] SAT_CNT = 8'd0;
`endif

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic [7:0]        out_data;
    logic [7:0]        overrun_cnt;
    logic              out_valid;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    rng_byte_serializer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the bytes still owed to the consumer, plus a count of dropped words.
    logic [7:0]  mq[$];
    logic        m_prev;
    int          m_drops;
    logic [18:0] exp_vec;
    wire  [18:0] obs_vec = {out_valid, out_last, busy, out_data, overrun_cnt};

    initial begin
        m_prev  = 1'b0;
        m_drops = 0;
        exp_vec = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_prev  = 1'b0;
                m_drops = 0;
            end else begin : m_step
                logic was_busy;
                logic r;
                was_busy = (mq.size() != 0);
                r        = in_valid && !m_prev;
                if (was_busy && out_ready) void'(mq.pop_front());
                if (r) begin
                    if (was_busy) m_drops++;
                    else for (int i = 0; i < NB; i++) mq.push_back(in_data[8*i +: 8]);
                end
                m_prev = in_valid;
            end
            begin : m_exp
                logic [7:0] cnt;
`ifdef RNG_SER_OVERRUN_CNT_EN
                cnt = (m_drops > 255) ? 8'hFF : 8'(m_drops);
`else
                cnt = 8'd0;
`endif
                exp_vec = {mq.size() != 0, mq.size() == 1, mq.size() != 0,
                           (mq.size() != 0) ? mq[0] : 8'h00, cnt};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_vec !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs_vec, 19'd0); end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (obs_vec !== 19'd0) begin errors++; $display("FAIL idle_after_reset: got %h want %h", obs_vec, 19'd0); end
    endtask

    task automatic test_basic();
        logic [7:0] got[$];
        for (int i = 0; i < NB; i++) in_data[8*i +: 8] = 8'(i);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < NB + 4; c++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL basic_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_last) begin
                checks++;
                if (out_data !== 8'h3F) begin errors++; $display("FAIL basic_last_byte: got %h want 3f", out_data); end
            end
            if (out_valid && out_ready) got.push_back(out_data);
        end
        checks++;
        if (got.size() != NB) begin errors++; $display("FAIL basic_count: got %0d want %0d", got.size(), NB); end
        for (int i = 0; i < got.size() && i < NB; i++) begin
            checks++;
            if (got[i] !== 8'(i)) begin errors++; $display("FAIL basic_byte %0d: got %h want %h", i, got[i], 8'(i)); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic       stalled;
        logic [7:0] held;
        for (int i = 0; i < NB; i++) in_data[8*i +: 8] = 8'(i);
        stalled = 1'b0; held = 8'd0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3 * NB + 10; c++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (stalled) begin
                checks++;
                if (out_data !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
            end
            out_ready = (c % 3 == 2);
            if (out_valid && out_ready) got.push_back(out_data);
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
        out_ready = 1'b1;
        checks++;
        if (got.size() != NB) begin errors++; $display("FAIL bp_count: got %0d want %0d", got.size(), NB); end
        for (int i = 0; i < got.size() && i < NB; i++) begin
            checks++;
            if (got[i] !== 8'(i)) begin errors++; $display("FAIL bp_byte %0d: got %h want %h", i, got[i], 8'(i)); end
        end
    endtask

    task automatic test_overrun();
        logic [DATA_W-1:0] a;
        logic [7:0]        got[$];
        logic              sent;
        a = rand_word(); sent = 1'b0;
        in_data = a; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < NB + 4; c++) begin
            tick();
            if (c == 0) in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL ovr_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_valid && got.size() == 10 && !sent) begin
                in_valid = 1'b1; in_data = rand_word(); sent = 1'b1;
            end
            if (out_valid && out_ready) got.push_back(out_data);
        end
        checks++;
        if (got.size() != NB) begin errors++; $display("FAIL ovr_count: got %0d want %0d", got.size(), NB); end
        for (int i = 0; i < got.size() && i < NB; i++) begin
            checks++;
            if (got[i] !== a[8*i +: 8]) begin errors++; $display("FAIL ovr_byte %0d: got %h want %h", i, got[i], a[8*i +: 8]); end
        end
        checks++;
        if (overrun_cnt !== ONE_CNT) begin errors++; $display("FAIL ovr_one: got %0d want %0d", overrun_cnt, ONE_CNT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ovr_no_second: busy %b want 0", busy); end
        for (int c = 0; c < 800; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL ovr_sat_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            in_valid = c[0];
            in_data  = rand_word();
        end
        in_valid = 1'b0;
        for (int c = 0; c < NB + 4; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL ovr_drain %0d: got %h want %h", c, obs_vec, exp_vec); end
        end
        checks++;
        if (overrun_cnt !== SAT_CNT) begin errors++; $display("FAIL ovr_saturate: got %0d want %0d", overrun_cnt, SAT_CNT); end
    endtask

    task automatic test_level();
        logic [DATA_W-1:0] w;
        int                n;
        w = rand_word(); n = 0;
        rst = 1'b1; in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL level_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== w[8*(n % NB) +: 8]) begin errors++; $display("FAIL level_byte %0d: got %h want %h", n, out_data, w[8*(n % NB) +: 8]); end
                n++;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (n != NB) begin errors++; $display("FAIL level_count: got %0d want %0d", n, NB); end
        checks++;
        if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL level_ovr: got %0d want 0", overrun_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] w2;
        logic [7:0]        got[$];
        int                n;
        w = rand_word(); n = 0;
        in_data = w; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < NB && n < 20; c++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL rmid_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_valid && out_ready) n++;
        end
        tick();
        checks++;
        if (out_data !== w[167:160]) begin errors++; $display("FAIL rmid_byte20: got %h want %h", out_data, w[167:160]); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, out_last} !== 3'b000) begin
            errors++; $display("FAIL rmid_async: got valid/busy/last %b want 000", {out_valid, busy, out_last});
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        w2 = rand_word();
        in_data = w2; in_valid = 1'b1;
        for (int c = 0; c < NB + 4; c++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL rmid_new_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_valid && out_ready) got.push_back(out_data);
        end
        checks++;
        if (got.size() != NB) begin errors++; $display("FAIL rmid_count: got %0d want %0d", got.size(), NB); end
        for (int i = 0; i < got.size() && i < NB; i++) begin
            checks++;
            if (got[i] !== w2[8*i +: 8]) begin errors++; $display("FAIL rmid_byte %0d: got %h want %h", i, got[i], w2[8*i +: 8]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] w2;
        logic              seen;
        logic              done;
        seen = 1'b0; done = 1'b0; w2 = rand_word();
        in_data = rand_word(); in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < NB + 10 && !done; c++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL b2b_cycle %0d: got %h want %h", c, obs_vec, exp_vec); end
            if (out_valid) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL b2b_timeout: stream end %b want 1", done); end
        in_data = w2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, w2[7:0]}) begin
            errors++; $display("FAIL b2b_restart: got %b/%h want 1/%h", out_valid, out_data, w2[7:0]);
        end
        for (int c = 0; c < NB + 2; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL b2b_drain %0d: got %h want %h", c, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_level();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_byte_serializer.md
# rng_byte_serializer

Downstream stage of the Fortuna accelerator. Captures each 512-bit random word when the generator's valid output rises, then streams the word out one byte at a time over a valid/ready handshake, least-significant byte first. A UART/host bridge or the FPGA top level can then consume the full word through an 8-bit path instead of only the low byte. Words that arrive while a stream is in progress are dropped and counted.

## Interface
Parameters:
- `DATA_W`, 512, captured word width in bits; must be a non-zero multiple of 8. NBYTES = DATA_W/8.

Ports:
- `clk`  in  1  single clock for all logic (the divided system clock).
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  valid_data from the generator; level signal, only its rising edge matters.
- `in_data`  in  DATA_W  out_rng_data word from the generator.
- `out_data`  out  8  current byte.
- `out_valid`  out  1  out_data holds a byte for the consumer.
- `out_ready`  in  1  consumer accepts the byte this cycle.
- `out_last`  out  1  the current byte is byte NBYTES-1 of the word.
- `busy`  out  1  a stream is in progress.
- `overrun_cnt`  out  8  saturating count of dropped words.

## Operation
- Registers: `in_valid_q` (previous in_valid), shift register `shreg` (DATA_W), byte index `idx` (clog2(NBYTES) bits), state, `overrun_cnt`.
- Rising edge `rise` = in_valid & ~in_valid_q. `in_valid_q` updates every cycle.
- FSM states:
  - IDLE: out_valid=0. On `rise`: shreg<=in_data, idx<=0, go to STREAM.
  - STREAM: out_valid=1, out_data=shreg[7:0], out_last=(idx==NBYTES-1). On out_valid&out_ready: if out_last, go to IDLE; otherwise shreg>>=8 and idx<=idx+1.
- out_data stays stable while out_valid=1 and out_ready=0. The consumer may hold out_ready high permanently.
- busy = (state==STREAM).
- Overrun: a `rise` in STREAM, including the cycle of the final handshake, drops the new word. overrun_cnt increments and saturates at 255. The stream in progress is unaffected.
- Reset (async, any time, including mid-stream): state=IDLE, in_valid_q=0, shreg=0, idx=0, overrun_cnt=0. The current stream is abandoned.
- If in_valid is already high when rst deasserts, this counts as a `rise` in the first clock after release.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun_cnt=0.
- When `rise` is sampled at edge N, out_valid=1 from edge N (registered state), with byte 0 = in_data[7:0] as captured at N.
- With out_ready held high: one byte per cycle, so NBYTES consecutive cycles (64 for default). out_last is high only on the final cycle. out_valid falls on the edge after the last handshake.
- The earliest accepted new `rise` is the cycle after returning to IDLE. The minimum word-to-word spacing is NBYTES+1 cycles.
- Output signals are purely registered or decoded from state only. There is no combinational path from out_ready to out_valid/out_data.

## Configuration
- `RNG_SER_OVERRUN_CNT_EN`:
  - Defined: overrun_cnt behaves as described.
  - Not defined: the counter register is not built, overrun_cnt is tied to 0, and overruns are still silently dropped.

## Test plan
- Basic stream: reset, in_valid 0->1 with in_data bytes i = i (0x00..0x3F), out_ready=1. Required: 64 bytes 0x00,0x01,…,0x3F on consecutive cycles; out_last only with 0x3F; busy low after.
- Backpressure: same word, out_ready toggles 1,0,0,1,… Required: byte sequence unchanged, out_data stable while stalled, no byte lost or duplicated.
- Overrun: a second rising edge of in_valid during byte 10. Required: first word completes intact, second word is not streamed, overrun_cnt=1. Then 300 overruns: overrun_cnt saturates at 255 (0 without RNG_SER_OVERRUN_CNT_EN).
- Level, not edge: in_valid held high for 200 cycles. Required: exactly one word streamed, overrun_cnt=0.
- Reset mid-stream: assert rst asynchronously at byte 20. Required: out_valid, busy and out_last go to 0 immediately. After release, a new rising edge streams the new word from byte 0.
- Back-to-back: a rising edge on the cycle after out_valid falls. Required: the word is captured and out_valid returns high on the next cycle.
